// File: rtl/syn_update_sweeper_if.sv
// Port bundle between the update sweeper, its sequencer (start/gate/hold)
// and the synaptic core it drives.
interface syn_update_sweeper_if;
    logic       start;
    logic       gate;
    logic       hold;
    logic       synarray_cs;
    logic       synarray_we;
    logic [9:0] pre_addr;
    logic [9:0] post_addr;
    logic       tref_event;
    logic       busy;
    logic       done;

    // master: the sweeper itself, driving the synaptic core
    modport master (
        input  start, gate, hold,
        output synarray_cs, synarray_we, pre_addr, post_addr,
               tref_event, busy, done
    );

    modport slave (
        output start, gate, hold,
        input  synarray_cs, synarray_we, pre_addr, post_addr,
               tref_event, busy, done
    );
endinterface

// File: rtl/syn_update_sweeper.sv
// Learning-update sweeper: walks the synaptic array as read / settle / write
// triples, one 32-bit word (four post weights) per triple.
module syn_update_sweeper #(
    parameter int N_PRE  = 784,
    parameter int N_POST = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    syn_update_sweeper_if.master sw
);

    localparam int         WORDS     = N_POST / 4;
    localparam logic [9:0] PRE_LAST  = 10'(N_PRE - 1);
    localparam logic [7:0] WORD_LAST = 8'(WORDS - 1);

    // state   | meaning
    // S_IDLE  | no sweep, counters and addresses at 0
    // S_PAUSE | between words, held by HOLD, addresses show next word
    // S_RD    | SRAM read of the current word
    // S_WT    | read data held, spike counts settle
    // S_WR    | write-back with update-enable pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_RD,
        S_WT,
        S_WR
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] pre_q, pre_d;
    logic [7:0] word_q, word_d;
    logic       cs_q, cs_d;
    logic       we_q, we_d;
    logic       tref_q, tref_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       last_word;

    assign last_word = (pre_q == PRE_LAST) && (word_q == WORD_LAST);

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        word_d  = word_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                pre_d  = '0;
                word_d = '0;
                if (sw.start && !sw.gate) begin
                    state_d = sw.hold ? S_PAUSE : S_RD;
                end
            end
            S_PAUSE: begin
                if (sw.gate) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    word_d  = '0;
                end else if (!sw.hold) begin
                    state_d = S_RD;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: state_d = S_WR;
            S_WR: begin
                if (last_word) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    word_d  = '0;
                    done_d  = 1'b1;
                end else if (sw.gate) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                    word_d  = '0;
                end else begin
                    if (word_q == WORD_LAST) begin
                        word_d = '0;
                        pre_d  = pre_q + 10'd1;
                    end else begin
                        word_d = word_q + 8'd1;
                    end
                    state_d = sw.hold ? S_PAUSE : S_RD;
                end
            end
            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
                word_d  = '0;
            end
        endcase

        // Decoded from the next state so the registered copies track state_q
        // exactly and never depend combinationally on an input.
        cs_d   = (state_d == S_RD) || (state_d == S_WR);
        we_d   = (state_d == S_WR);
        tref_d = (state_d == S_WR);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
            word_q  <= '0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            tref_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            word_q  <= word_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            tref_q  <= tref_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sw.synarray_cs = cs_q;
    assign sw.synarray_we = we_q;
    assign sw.tref_event  = tref_q;
    assign sw.busy        = busy_q;
    assign sw.done        = done_q;
    assign sw.pre_addr    = pre_q;
    assign sw.post_addr   = {word_q, 2'b00};

endmodule

// File: tb/tb_syn_update_sweeper.sv
// Directed bench for syn_update_sweeper with a 3 x 8 array (two words per row).
module tb_syn_update_sweeper;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    syn_update_sweeper_if u_if ();

    syn_update_sweeper #(
        .N_PRE  (3),
        .N_POST (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (u_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input bit cs, input bit we, input bit tref,
                               input bit busy, input bit done, input int pre, input int post);
        chk({tag, ".cs"},   32'(u_if.synarray_cs), 32'(cs));
        chk({tag, ".we"},   32'(u_if.synarray_we), 32'(we));
        chk({tag, ".tref"}, 32'(u_if.tref_event),  32'(tref));
        chk({tag, ".busy"}, 32'(u_if.busy),        32'(busy));
        chk({tag, ".done"}, 32'(u_if.done),        32'(done));
        chk({tag, ".pre"},  32'(u_if.pre_addr),    32'(pre));
        chk({tag, ".post"}, 32'(u_if.post_addr),   32'(post));
    endtask

    // Check the current cycle, then move to the next sample point.
    task automatic expect_cyc(input string tag, input bit cs, input bit we, input bit tref,
                              input bit busy, input bit done, input int pre, input int post);
        chk_outputs(tag, cs, we, tref, busy, done, pre, post);
        @(negedge clk);
    endtask

    task automatic triple(input string tag, input int pre, input int post);
        expect_cyc({tag, ".rd"}, 1, 0, 0, 1, 0, pre, post);
        expect_cyc({tag, ".wt"}, 0, 0, 0, 1, 0, pre, post);
        expect_cyc({tag, ".wr"}, 1, 1, 1, 1, 0, pre, post);
    endtask

    // Full sweep from (0,0) plus its DONE cycle; optionally inject a START
    // during a WT and/or re-request in the DONE cycle.
    task automatic sweep(input string tag, input bit restart, input bit spurious);
        for (int p = 0; p < 3; p++) begin
            for (int w = 0; w < 2; w++) begin
                expect_cyc({tag, ".rd"}, 1, 0, 0, 1, 0, p, w * 4);
                if (spurious && p == 1 && w == 0) u_if.start = 1'b1;
                expect_cyc({tag, ".wt"}, 0, 0, 0, 1, 0, p, w * 4);
                u_if.start = 1'b0;
                expect_cyc({tag, ".wr"}, 1, 1, 1, 1, 0, p, w * 4);
            end
        end
        if (restart) u_if.start = 1'b1;
        expect_cyc({tag, ".done"}, 0, 0, 0, 0, 1, 0, 0);
        u_if.start = 1'b0;
    endtask

    task automatic kick();
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        u_if.start = 1'b0;
        u_if.gate  = 1'b0;
        u_if.hold  = 1'b0;

        @(negedge clk);
        chk_outputs("reset", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_cyc("idle", 0, 0, 0, 0, 0, 0, 0);

        // Basic sweep: 18 busy cycles, DONE in cycle 19, then quiet.
        kick();
        sweep("basic", 0, 0);
        expect_cyc("basic.after", 0, 0, 0, 0, 0, 0, 0);

        // HOLD raised in the WR of (1,0) for 5 cycles -> 5 PAUSE cycles at (1,4).
        kick();
        triple("hold.w00", 0, 0);
        triple("hold.w04", 0, 4);
        expect_cyc("hold.w10.rd", 1, 0, 0, 1, 0, 1, 0);
        expect_cyc("hold.w10.wt", 0, 0, 0, 1, 0, 1, 0);
        u_if.hold = 1'b1;
        expect_cyc("hold.w10.wr", 1, 1, 1, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            u_if.hold = (i < 4);
            expect_cyc("hold.pause", 0, 0, 0, 1, 0, 1, 4);
        end
        u_if.hold = 1'b0;
        triple("hold.w14", 1, 4);
        triple("hold.w20", 2, 0);
        triple("hold.w24", 2, 4);
        expect_cyc("hold.done", 0, 0, 0, 0, 1, 0, 0);

        // GATE in the WT of (1,4): the write still happens, then abort.
        kick();
        triple("gate.w00", 0, 0);
        triple("gate.w04", 0, 4);
        triple("gate.w10", 1, 0);
        expect_cyc("gate.w14.rd", 1, 0, 0, 1, 0, 1, 4);
        u_if.gate = 1'b1;
        expect_cyc("gate.w14.wt", 0, 0, 0, 1, 0, 1, 4);
        expect_cyc("gate.w14.wr", 1, 1, 1, 1, 0, 1, 4);
        expect_cyc("gate.abort", 0, 0, 0, 0, 0, 0, 0);
        u_if.start = 1'b1;
        expect_cyc("gate.blocked_start", 0, 0, 0, 0, 0, 0, 0);
        u_if.start = 1'b0;
        expect_cyc("gate.still_idle", 0, 0, 0, 0, 0, 0, 0);
        u_if.gate = 1'b0;

        // Asynchronous reset in the WT of (0,4).
        kick();
        triple("rst.w00", 0, 0);
        expect_cyc("rst.w04.rd", 1, 0, 0, 1, 0, 0, 4);
        chk_outputs("rst.w04.wt", 0, 0, 0, 1, 0, 0, 4);
        #2 rst_n = 1'b0;
        #1 chk_outputs("rst.async", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk_outputs("rst.held", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(negedge clk);
        expect_cyc("rst.idle", 0, 0, 0, 0, 0, 0, 0);
        kick();
        sweep("rst.sweep", 0, 0);

        // Back-to-back: restart in the DONE cycle, stray START mid-sweep.
        kick();
        sweep("b2b.first", 1, 1);
        sweep("b2b.second", 0, 1);
        expect_cyc("b2b.after", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syn_update_sweeper.md
# syn_update_sweeper

Sweep controller placed directly upstream of the synaptic core. On a learning-update request it walks the whole synaptic array in read-modify-write order. For every 32-bit word (four 8-bit post-synaptic weights) it drives:
- a read cycle;
- a settle cycle, for SRAM output and spike-count fetch;
- a write cycle with the update-enable pulse.

It produces the synaptic core's chip-select, write-enable, pre/post neuron addresses and update-event inputs.

## Interface
Parameters:
- N_PRE, 784, number of pre-synaptic neurons (1..1024)
- N_POST, 8, number of post-synaptic neurons; multiple of 4, 4..256; WORDS = N_POST/4

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- START  in  1  one-cycle sweep request (update time-step boundary)
- GATE  in  1  SPI gate-activity (synchronized); high blocks/aborts sweeps
- HOLD  in  1  controller pause request; honoured only between words
- SYNARRAY_CS  out  1  synaptic SRAM chip select
- SYNARRAY_WE  out  1  synaptic SRAM write enable
- PRE_ADDR  out  10  pre-neuron address
- POST_ADDR  out  10  post-neuron address, {word[7:0], 2'b00}
- TREF_EVENT  out  1  weight-update enable, high only in write cycle
- BUSY  out  1  sweep in progress
- DONE  out  1  one-cycle pulse after last word written

## Operation
- States: IDLE, PAUSE, RD, WT, WR.
- Counters:
  - pre (10 b, 0..N_PRE-1), outer loop;
  - word (8 b, 0..WORDS-1), inner loop;
  - both cleared in IDLE.
- IDLE:
  - START=1 and GATE=0 -> RD if HOLD=0, else PAUSE.
  - START with GATE=1 is ignored.
- PAUSE: CS=0. HOLD=0 -> RD. GATE=1 -> IDLE (abort).
- RD: CS=1, WE=0. Always -> WT.
- WT: CS=0, WE=0. SRAM holds read data; spike counts settle. Always -> WR.
- WR: CS=1, WE=1, TREF_EVENT=1, same address as RD. Then, in priority order:
  1. Last word (pre=N_PRE-1, word=WORDS-1) -> IDLE, DONE=1 next cycle.
  2. Else GATE=1 -> IDLE, no DONE (abort).
  3. Else advance counters (word+1; on wrap word=0, pre+1) -> RD if HOLD=0, else PAUSE.
- Address stability: PRE_ADDR/POST_ADDR equal the counters in RD, WT, WR and PAUSE. They are 0 in IDLE.
- Output decode:
  - CS, WE, TREF_EVENT, BUSY are decoded from the registered state only; there is no combinational path from any input.
  - BUSY=1 in every state except IDLE.
- Ignored inputs:
  - START while BUSY is ignored; no queuing.
  - HOLD and GATE are ignored in RD and WT. An RMW once started always completes its write.

## Timing
- Reset values: every output 0; state IDLE; counters 0. The reset is asynchronous, so CS/WE drop immediately when RST_N falls, including mid-RMW. No write completes after reset assertion.
- Sweep start: START sampled at edge t puts state RD in cycle t+1, with PRE_ADDR=0, POST_ADDR=0.
- Per-word cadence: RD, WT, WR on 3 consecutive cycles; 3 cycles per word with HOLD=0.
- Sweep length: 3*N_PRE*WORDS cycles of BUSY.
- End of sweep: DONE is high for exactly 1 cycle, the cycle after the final WR. BUSY is 0 in that same cycle.
- Restart: START accepted in the DONE cycle begins a new sweep (RD next cycle).
- HOLD latency: HOLD sampled in WR pauses before the next RD. Each PAUSE cycle adds 1 cycle.
- Degenerate sizes: N_PRE=1 with WORDS=1 gives a single 3-cycle sweep. Counter wrap is exact at N_PRE-1 and WORDS-1; no address beyond range is ever driven.
- Data path: write data is formed downstream from read data in WT/WR. This block has no data-path latency of its own.

## Test plan
- Basic sweep (N_PRE=3, N_POST=8): single START.
  - Required: 6 RMW triples in 18 BUSY cycles.
  - Addresses, in order: (0,0),(0,4),(1,0),(1,4),(2,0),(2,4).
  - CS pattern 1,0,1 per triple; WE and TREF_EVENT high only in the 3rd cycle of each triple.
  - DONE in cycle 19.
- HOLD: raise HOLD for 5 cycles during the WR of word (1,0).
  - Required: PAUSE for 5 cycles with CS=0 and addresses held at (1,4).
  - Then RD resumes; total BUSY = 23 cycles.
- GATE abort: GATE=1 in the WT of (1,4).
  - Required: WR of (1,4) still occurs, then IDLE.
  - No DONE, BUSY=0, addresses return to 0.
  - START with GATE=1 leaves BUSY at 0.
- Reset mid-RMW: RST_N low during WT of (0,4).
  - Required: all outputs 0 asynchronously, no WE.
  - After release, START gives a full sweep from (0,0).
- Back-to-back: START in the DONE cycle.
  - Required: a second sweep starts the next cycle, with addresses restarting at (0,0).
  - START pulses during BUSY have no effect on the cycle count.
